// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: Dcache has priority, Icache has a starvation override.
// Accepted load tags are recorded in an owner table so returns route back to the issuer.
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Icache2mem_command,
  input  logic [XLEN-1:0] Icache2mem_addr,
  input  logic [1:0]      Dcache2mem_command,
  input  logic [XLEN-1:0] Dcache2mem_addr,
  input  logic [63:0]     Dcache2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      Imem2proc_response,
  output logic [63:0]     Imem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Dmem2proc_tag,
  output logic            grant_dcache,
  output logic            orphan_tag
);

  localparam logic [1:0] BusNone = 2'd0;
  localparam logic [1:0] BusLoad = 2'd1;
  localparam logic [2:0] Limit   = 3'(STARVE_LIMIT);

  logic [2:0]  starve_q, starve_d;
  // Bit 0 is never set: tag 0 means "no tag".
  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;  // 0 = Icache, 1 = Dcache

  logic i_act, d_act, grant_i, grant_d;
  logic ret_hit, ret_owner;

  // Arbitration: Dcache first unless Icache has lost Limit cycles in a row.
  always_comb begin
    i_act   = !reset && (Icache2mem_command != BusNone);
    d_act   = !reset && (Dcache2mem_command != BusNone);
    grant_i = i_act && (!d_act || (starve_q == Limit));
    grant_d = d_act && !grant_i;
  end

  // Drive the memory bus from the winner and forward the accept tag to it alone.
  always_comb begin
    proc2mem_command   = BusNone;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    grant_dcache       = grant_d;
    if (grant_d) begin
      proc2mem_command   = Dcache2mem_command;
      proc2mem_addr      = Dcache2mem_addr;
      proc2mem_data      = Dcache2mem_data;
      Dmem2proc_response = mem2proc_response;
    end else if (grant_i) begin
      proc2mem_command   = Icache2mem_command;
      proc2mem_addr      = Icache2mem_addr;
      Imem2proc_response = mem2proc_response;
    end
  end

  // Route returned data to the recorded owner; unknown tags are flagged as orphans.
  always_comb begin
    ret_hit        = !reset && (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    ret_owner      = owner_q[mem2proc_tag];
    orphan_tag     = !reset && (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
    Imem2proc_tag  = '0;
    Imem2proc_data = '0;
    Dmem2proc_tag  = '0;
    Dmem2proc_data = '0;
    if (ret_hit && !ret_owner) begin
      Imem2proc_tag  = mem2proc_tag;
      Imem2proc_data = mem2proc_data;
    end
    if (ret_hit && ret_owner) begin
      Dmem2proc_tag  = mem2proc_tag;
      Dmem2proc_data = mem2proc_data;
    end
  end

  // Next state: starvation count and owner table (allocation applied after the
  // return clear so a same-cycle re-accept of the same tag keeps the entry).
  always_comb begin
    if (i_act && !grant_i) begin
      starve_d = (starve_q >= Limit) ? starve_q : starve_q + 3'd1;
    end else begin
      starve_d = 3'd0;
    end
    valid_d = valid_q;
    owner_d = owner_q;
    if (ret_hit) begin
      valid_d[mem2proc_tag] = 1'b0;
    end
    if ((proc2mem_command == BusLoad) && (mem2proc_response != 4'd0)) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= 3'd0;
      valid_q  <= '0;
      owner_q  <= '0;
    end else begin
      starve_q <= starve_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a tag-ownership model.
module tb_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clock, reset;
  logic [1:0]      icmd, dcmd;
  logic [XLEN-1:0] iaddr, daddr;
  logic [63:0]     ddata, rdata;
  logic [3:0]      resp, rtag;

  logic [1:0]      p_cmd;
  logic [XLEN-1:0] p_addr;
  logic [63:0]     p_data, i_data, d_data;
  logic [3:0]      i_resp, d_resp, i_tag, d_tag;
  logic            gnt_d, orphan;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Model state: owner per tag (-1 none, 0 Icache, 1 Dcache) and Icache losing streak.
  int m_owner[16];
  int m_loss = 0;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clock              (clock),
    .reset              (reset),
    .Icache2mem_command (icmd),
    .Icache2mem_addr    (iaddr),
    .Dcache2mem_command (dcmd),
    .Dcache2mem_addr    (daddr),
    .Dcache2mem_data    (ddata),
    .mem2proc_response  (resp),
    .mem2proc_data      (rdata),
    .mem2proc_tag       (rtag),
    .proc2mem_command   (p_cmd),
    .proc2mem_addr      (p_addr),
    .proc2mem_data      (p_data),
    .Imem2proc_response (i_resp),
    .Imem2proc_data     (i_data),
    .Imem2proc_tag      (i_tag),
    .Dmem2proc_response (d_resp),
    .Dmem2proc_data     (d_data),
    .Dmem2proc_tag      (d_tag),
    .grant_dcache       (gnt_d),
    .orphan_tag         (orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    icmd  = 2'd0;
    dcmd  = 2'd0;
    iaddr = '0;
    daddr = '0;
    ddata = '0;
    resp  = 4'd0;
    rtag  = 4'd0;
    rdata = '0;
  endtask

  // Move past the next rising edge before changing inputs.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample mid-cycle, compare every output with the model, then advance the model.
  task automatic step();
    logic [1:0]      e_cmd;
    logic [XLEN-1:0] e_addr;
    logic [63:0]     e_data, e_id, e_dd;
    logic [3:0]      e_ir, e_dr, e_it, e_dt;
    logic            e_gd, e_orph;
    bit              ia, da, iw, dw;
    @(negedge clock);
    e_cmd = 2'd0; e_addr = '0; e_data = '0; e_id = '0; e_dd = '0;
    e_ir = 4'd0; e_dr = 4'd0; e_it = 4'd0; e_dt = 4'd0; e_gd = 1'b0; e_orph = 1'b0;
    ia = 1'b0; da = 1'b0; iw = 1'b0; dw = 1'b0;
    if (!reset) begin
      ia = (icmd != 2'd0);
      da = (dcmd != 2'd0);
      iw = ia && (!da || (m_loss == LIMIT));
      dw = da && !iw;
      if (dw) begin
        e_cmd = dcmd; e_addr = daddr; e_data = ddata; e_dr = resp; e_gd = 1'b1;
      end else if (iw) begin
        e_cmd = icmd; e_addr = iaddr; e_ir = resp;
      end
      if (rtag != 4'd0) begin
        if (m_owner[rtag] == 0) begin
          e_it = rtag; e_id = rdata;
        end else if (m_owner[rtag] == 1) begin
          e_dt = rtag; e_dd = rdata;
        end else begin
          e_orph = 1'b1;
        end
      end
    end
    chk("cmd", p_cmd, e_cmd);
    chk("addr", p_addr, e_addr);
    chk("wdata", p_data, e_data);
    chk("i_resp", i_resp, e_ir);
    chk("d_resp", d_resp, e_dr);
    chk("i_tag", i_tag, e_it);
    chk("i_data", i_data, e_id);
    chk("d_tag", d_tag, e_dt);
    chk("d_data", d_data, e_dd);
    chk("grant_d", gnt_d, e_gd);
    chk("orphan", orphan, e_orph);
    if (reset) begin
      foreach (m_owner[t]) m_owner[t] = -1;
      m_loss = 0;
    end else begin
      if (ia && !iw) m_loss = (m_loss < LIMIT) ? m_loss + 1 : LIMIT;
      else m_loss = 0;
      if (rtag != 4'd0) m_owner[rtag] = -1;
      if ((iw || dw) && (e_cmd == 2'd1) && (resp != 4'd0)) m_owner[resp] = dw ? 1 : 0;
    end
  endtask

  initial begin
    foreach (m_owner[t]) m_owner[t] = -1;
    // Reset with activity on every input: outputs must stay quiet.
    reset = 1'b1;
    idle();
    icmd = 2'd1; dcmd = 2'd2; resp = 4'd5; rtag = 4'd4; rdata = 64'h55;
    step();
    chk("rst_cmd", p_cmd, 2'd0);
    chk("rst_gnt", gnt_d, 1'b0);
    chk("rst_orph", orphan, 1'b0);
    tick(); step();
    tick(); reset = 1'b0; idle();

    // Single Icache load, tag 3 returns five cycles later.
    icmd = 2'd1; iaddr = 'h100; resp = 4'd3;
    step();
    chk("s1_addr", p_addr, 'h100);
    chk("s1_iresp", i_resp, 4'd3);
    chk("s1_dresp", d_resp, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); idle(); step();
    end
    tick(); idle(); rtag = 4'd3; rdata = 64'hDEAD;
    step();
    chk("s1_itag", i_tag, 4'd3);
    chk("s1_idata", i_data, 64'hDEAD);
    chk("s1_dtag", d_tag, 4'd0);
    chk("s1_ddata", d_data, 64'd0);

    // Both active: Dcache wins four cycles, Icache the fifth, then Dcache again.
    for (int k = 0; k < 6; k++) begin
      tick(); idle();
      icmd = 2'd1; iaddr = 'h200 + 8 * k; dcmd = 2'd1; daddr = 'h300 + k; resp = 4'(10 + k);
      step();
      chk("s2_grant", gnt_d, (k == 4) ? 1'b0 : 1'b1);
    end

    // Store allocates nothing, so its tag comes back as an orphan.
    tick(); idle(); dcmd = 2'd2; daddr = 'h40; ddata = 64'h1234_5678_9abc_def0; resp = 4'd7;
    step();
    chk("s3_cmd", p_cmd, 2'd2);
    chk("s3_wdata", p_data, 64'h1234_5678_9abc_def0);
    tick(); idle(); rtag = 4'd7; rdata = 64'h77;
    step();
    chk("s3_orph", orphan, 1'b1);
    chk("s3_itag", i_tag, 4'd0);
    chk("s3_dtag", d_tag, 4'd0);

    // Tag 2 returns to Icache while being re-accepted for Dcache.
    tick(); idle(); icmd = 2'd1; iaddr = 'h80; resp = 4'd2;
    step();
    tick(); idle(); dcmd = 2'd1; daddr = 'h90; resp = 4'd2; rtag = 4'd2; rdata = 64'hAAAA;
    step();
    chk("s4_itag", i_tag, 4'd2);
    chk("s4_idata", i_data, 64'hAAAA);
    chk("s4_dtag", d_tag, 4'd0);
    chk("s4_dresp", d_resp, 4'd2);
    tick(); idle(); rtag = 4'd2; rdata = 64'hBBBB;
    step();
    chk("s4_dtag2", d_tag, 4'd2);
    chk("s4_ddata2", d_data, 64'hBBBB);
    chk("s4_itag2", i_tag, 4'd0);

    // Tags 4 and 9 outstanding across reset become orphans.
    tick(); idle(); icmd = 2'd1; iaddr = 'hC0; resp = 4'd4;
    step();
    tick(); idle(); dcmd = 2'd1; daddr = 'hD0; resp = 4'd9;
    step();
    tick(); idle(); reset = 1'b1; icmd = 2'd1; resp = 4'd6; rtag = 4'd9; rdata = 64'h99;
    step();
    chk("s5_iresp", i_resp, 4'd0);
    chk("s5_dtag", d_tag, 4'd0);
    chk("s5_cmd", p_cmd, 2'd0);
    chk("s5_orph", orphan, 1'b0);
    tick(); reset = 1'b0; idle(); rtag = 4'd4; rdata = 64'h44;
    step();
    chk("s5_orph2", orphan, 1'b1);
    chk("s5_itag2", i_tag, 4'd0);

    // Rejected Dcache load: no response forwarded, starvation count still zero.
    tick(); idle(); dcmd = 2'd1; daddr = 'hE0; resp = 4'd0;
    step();
    chk("s6_grant", gnt_d, 1'b1);
    chk("s6_dresp", d_resp, 4'd0);
    tick(); idle(); icmd = 2'd1; dcmd = 2'd1; resp = 4'd0;
    step();
    chk("s6_grant2", gnt_d, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tick();
      reset = ($urandom_range(63) == 0);
      icmd  = 2'($urandom_range(1));
      iaddr = $urandom & ~32'h7;
      dcmd  = 2'($urandom_range(2));
      daddr = $urandom;
      ddata = {$urandom, $urandom};
      resp  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      rtag  = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      rdata = {$urandom, $urandom};
      step();
    end

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles an Icache request may lose before it is forced to win.
REQ-002 Ports (name  direction  width  meaning):
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- Icache2mem_command  in  2  BUS_NONE/BUS_LOAD; Icache issues only loads.
- Icache2mem_addr  in  XLEN  8-byte-aligned fetch address.
- Dcache2mem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE.
- Dcache2mem_addr  in  XLEN  load/store address.
- Dcache2mem_data  in  64  store data.
- mem2proc_response  in  4  tag accepted this cycle; 0 means rejected.
- mem2proc_data  in  64  returned load data.
- mem2proc_tag  in  4  tag of returned data; 0 means none.
- proc2mem_command  out  2  command to memory.
- proc2mem_addr  out  XLEN  address to memory.
- proc2mem_data  out  64  store data to memory.
- Imem2proc_response / Dmem2proc_response  out  4 each  routed accept tag.
- Imem2proc_data / Dmem2proc_data  out  64 each  routed return data.
- Imem2proc_tag / Dmem2proc_tag  out  4 each  routed return tag.
- grant_dcache  out  1  1 when Dcache owns the bus this cycle.
- orphan_tag  out  1  one-cycle pulse: nonzero return tag with no owner entry.

Function
REQ-003 Arbitration is combinational and selects at most one requester per cycle; a requester is active when its command is not BUS_NONE.
REQ-004 Default priority: Dcache over Icache.
REQ-005 Starvation counter (3 bits, saturating at STARVE_LIMIT) increments each cycle Icache is active and loses; clears to 0 each cycle Icache wins or is inactive.
REQ-006 When the counter equals STARVE_LIMIT and Icache is active, Icache wins regardless of Dcache.
REQ-007 The winner's command, address and data (data 0 for Icache) drive proc2mem_*; with no winner, proc2mem_command = BUS_NONE, addr = 0, data = 0.
REQ-008 mem2proc_response is forwarded to the winner's *mem2proc_response only; the loser and idle requester see 0 in the same cycle.
REQ-009 Owner table: 15 entries indexed by tags 1..15, each holding valid bit and owner bit (0 = Icache, 1 = Dcache).
REQ-010 A granted BUS_LOAD with nonzero mem2proc_response sets the entry for that tag at the next posedge (valid = 1, owner = winner).
REQ-011 A BUS_STORE never allocates an entry.
REQ-012 Nonzero mem2proc_tag with a valid entry routes mem2proc_data and mem2proc_tag to the owner's outputs in the same cycle; the other requester sees tag 0 and data 0.
REQ-013 That entry clears at the next posedge.
REQ-014 Nonzero mem2proc_tag with no valid entry: the tag goes to neither requester and orphan_tag = 1 that cycle.
REQ-015 If the same tag returns and is re-accepted in one cycle, routing uses the old owner and the entry ends valid with the new owner (set wins over clear).
REQ-016 Acceptance of a tag whose entry is already valid overwrites the entry; no other side effect.
REQ-017 mem2proc_tag = 0 routes nothing; both *mem2proc_tag outputs are 0.
REQ-018 Rejection (response 0) allocates nothing and counts as a loss for neither requester; the starvation counter sees only arbitration losses.
REQ-019 Latency: grant/response forwarding 0 cycles; table update 1 cycle.

Reset
REQ-020 While reset = 1:
- proc2mem_command = BUS_NONE; proc2mem_addr = 0; proc2mem_data = 0.
- all I/D response, tag and data outputs = 0; grant_dcache = 0; orphan_tag = 0.
REQ-021 At a posedge with reset = 1, all owner entries become invalid and the starvation counter becomes 0.
REQ-022 Returns in flight across reset are treated as orphans afterward.

Verification
REQ-023 The bench shall cover:
- Single Icache load 0x100; response 3; tag 3 returns 5 cycles later with data 0xDEAD -> Imem2proc_tag = 3, Imem2proc_data = 0xDEAD, D outputs 0.
- Both active every cycle, STARVE_LIMIT = 4 -> Dcache wins 4 cycles, Icache wins the 5th, counter returns to 0.
- Dcache store, response 7 -> no entry; later mem2proc_tag = 7 -> orphan_tag = 1, nothing routed.
- Icache load owns tag 2; in the cycle tag 2 returns, Dcache load is accepted with tag 2 -> return goes to Icache; the next return of tag 2 goes to Dcache.
- Reset asserted with tags 4 and 9 outstanding -> outputs 0 during reset; tag 4 returning after reset -> orphan_tag = 1.
- Dcache load rejected (response 0) -> no entry allocated; Dmem2proc_response = 0; starvation counter unchanged.
